load_store_unit: RTL and testbench

Initiator for the word-wide data Memory. It takes one byte, halfword or word load/store request at a time from the datapath and drives the Memory's `ren`/`wen`/`addr`/`din` handshake. It sign- or zero-extends load data and performs read-modify-write for sub-word stores. It sits between the MEM stage and the data Memory and stalls the requester via `ready` until each access completes.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: one access at a time, big-endian lanes,
// sign/zero extension on loads and read-modify-write for byte/halfword stores.
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mdin_q, mdin_d;

    logic accept, req_bad, req_word_store;

    // op = {store, unsigned, size[1:0]}
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            r[15:0] = wd;
        end else begin
            r[31:16] = wd;
        end
        return r;
    endfunction

    always_comb begin
        accept = ready_q && req_valid;
        case (req_op[1:0])
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
        req_word_store = req_op[3] && (req_op[1:0] == 2'b10);
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_bad)             state_d = StResp;
                    else if (req_word_store) state_d = StWr;
                    else                     state_d = StRd;
                end
            end
            StRd:    state_d = op_q[3] ? StWr : StResp;
            StWr:    state_d = StResp;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so every output is a flop.
    always_comb begin
        op_d    = op_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        err_d   = 1'b0;
        ren_d   = (state_d == StRd);
        wen_d   = (state_d == StWr);
        done_d  = (state_d == StResp);
        ready_d = (state_d == StIdle);
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = req_op;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    maddr_d = {2'b00, req_addr[31:2]};
                    if (req_bad) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (req_word_store) begin
                        mdin_d = req_wdata;
                    end
                end
            end
            StRd: begin
                if (op_q[3]) mdin_d  = store_merge(mem_dout, off_q, op_q[1:0], wdata_q);
                else         rdata_d = load_extend(mem_dout, off_q, op_q[1:0], op_q[2]);
            end
            StWr:    rdata_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
            mdin_q  <= '0;
        end else begin
            op_q    <= op_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_ren  = ren_q;
    assign mem_wen  = wen_q;
    assign mem_addr = maddr_q;
    assign mem_din  = mdin_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory plus an expected-result queue per access.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ready, done, err, mem_ren, mem_wen;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad = 0;
    int clash = 0;
    int done_seen = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nren;
        int          nwen;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [3:0] OpLb = 4'b0000, OpLbu = 4'b0100, OpLh = 4'b0001, OpLhu = 4'b0101;
    localparam logic [3:0] OpLw = 4'b0010, OpSb = 4'b1000, OpSh = 4'b1001, OpSw = 4'b1010;
    localparam logic [3:0] OpBad = 4'b0011;

    load_store_unit dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clock = ~clock;

    assign mem_dout = mem[mem_addr[7:0]];

    always @(negedge clock) begin
        if (reset && mem_wen) mem[mem_addr[7:0]] <= mem_din;
    end

    always @(negedge clock) begin
        if (mem_ren && mem_wen) clash++;
        if (done) done_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_ren, input int exp_wen);
        exp_t        e;
        int          k, nr, nw, lat;
        logic        got;
        logic [31:0] seen;
        e = '{rdata: exp_rd, err: exp_err, lat: exp_lat, nren: exp_ren, nwen: exp_wen};
        sb_q.push_back(e);
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        nr = 0; nw = 0; lat = 0; got = 1'b0; seen = '0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clock);
            if (mem_ren) begin nr++; seen = mem_addr; end
            if (mem_wen) begin nw++; seen = mem_addr; end
            if (done) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        e = sb_q.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_rdata"}, rdata, e.rdata);
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        chk({tag, "_nren"}, 32'(nr), 32'(e.nren));
        chk({tag, "_nwen"}, 32'(nw), 32'(e.nwen));
        if (nr + nw != 0) chk({tag, "_maddr"}, seen, {2'b00, addr[31:2]});
    endtask

    logic [31:0] lb_u [4] = '{32'h80, 32'hFF, 32'h7F, 32'h01};
    logic [31:0] lb_s [4] = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h7F, 32'h01};

    initial begin
        int base, k;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobes", {30'b0, mem_ren, mem_wen}, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mdin", mem_din, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_ready", 32'(ready), 1);

        txn("sw10", OpSw, 32'h10, 32'h12345678, 32'h0, 1'b0, 2, 0, 1);
        chk("sw10_mem", mem[4], 32'h12345678);
        txn("lw10", OpLw, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, 1, 0);

        txn("sw20", OpSw, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 2, 0, 1);
        txn("sb21", OpSb, 32'h21, 32'hFFFFFF80, 32'h0, 1'b0, 3, 1, 1);
        txn("lw20a", OpLw, 32'h20, 32'h0, 32'hAA80CCDD, 1'b0, 2, 1, 0);
        txn("sh22", OpSh, 32'h22, 32'h5555BEEF, 32'h0, 1'b0, 3, 1, 1);
        txn("lw20b", OpLw, 32'h20, 32'h0, 32'hAA80BEEF, 1'b0, 2, 1, 0);

        txn("sw30", OpSw, 32'h30, 32'h80FF7F01, 32'h0, 1'b0, 2, 0, 1);
        for (int b = 0; b < 4; b++) begin
            txn($sformatf("lbu3%0d", b), OpLbu, 32'h30 + b, 32'h0, lb_u[b], 1'b0, 2, 1, 0);
            txn($sformatf("lb3%0d", b), OpLb, 32'h30 + b, 32'h0, lb_s[b], 1'b0, 2, 1, 0);
        end
        txn("lh30", OpLh, 32'h30, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0);
        txn("lh32", OpLh, 32'h32, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0);
        txn("lhu30", OpLhu, 32'h30, 32'h0, 32'h000080FF, 1'b0, 2, 1, 0);
        txn("lhu32", OpLhu, 32'h32, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0);

        txn("e_lh31", OpLh, 32'h31, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        txn("e_lw22", OpLw, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        txn("e_size", OpBad, 32'h30, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        txn("e_sw21", OpSw, 32'h21, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 0);
        txn("e_sh33", OpSh, 32'h33, 32'h0000DEAD, 32'h0, 1'b1, 1, 0, 0);
        chk("e_mem20", mem[8], 32'hAA80BEEF);
        chk("e_mem30", mem[12], 32'h80FF7F01);

        // Reset lands in the WR cycle of a halfword store.
        k = 0;
        while (!ready && k < 20) begin @(negedge clock); k++; end
        req_valid = 1'b1;
        req_op    = OpSh;
        req_addr  = 32'h30;
        req_wdata = 32'h00001234;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        #1 base = done_seen;
        k = 0;
        while (!mem_wen && k < 10) begin @(negedge clock); k++; end
        chk("rst_saw_wr", 32'(mem_wen), 1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_ready", 32'(ready), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_strobes", {30'b0, mem_ren, mem_wen}, 0);
        chk("mid_rdata", rdata, 0);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        chk("mid_no_done", 32'(done_seen - base), 0);
        chk("mid_ready_back", 32'(ready), 1);
        v = mem[12];
        chk("mid_word_whole", 32'((v == 32'h80FF7F01) || (v == 32'h12347F01)), 1);
        txn("post_lw20", OpLw, 32'h20, 32'h0, 32'hAA80BEEF, 1'b0, 2, 1, 0);

        chk("ren_wen_excl", 32'(clash), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
